// File: rtl/rv_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : rv_alu_mc
// Description : Multi-cycle integer ALU for an rv32/rv64 execute stage.
//               Add/sub/logic/compare complete in one cycle; shifts run on an
//               iterative shifter moving up to SHIFT_STEP bits per cycle.
//               Valid/ready handshakes on both sides, a tag rides with each
//               op, and a cancel input flushes in-flight or held results.
//               Optional feature macro: ALU_BYPASS_EN (regfile writeback
//               bypass applied to the operands in the accept cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module rv_alu_mc #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1,
  parameter int unsigned TAG_W      = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic              op_w,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [4:0]        a_idx,
  input  logic [4:0]        b_idx,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [4:0]        byp_idx,
  input  logic [XLEN-1:0]   byp_val,
  input  logic              cancel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic [TAG_W-1:0]  tag_out,
  output logic              illegal
);

  // Shift-amount width, plus one spare bit so SHIFT_STEP == XLEN is representable.
  localparam int unsigned       c_shw  = $clog2(XLEN);
  localparam int unsigned       c_remw = c_shw + 1;
  localparam logic [c_remw-1:0] c_step = c_remw'(SHIFT_STEP);

  localparam logic [3:0] c_op_add  = 4'd0;
  localparam logic [3:0] c_op_sub  = 4'd1;
  localparam logic [3:0] c_op_and  = 4'd2;
  localparam logic [3:0] c_op_or   = 4'd3;
  localparam logic [3:0] c_op_xor  = 4'd4;
  localparam logic [3:0] c_op_slt  = 4'd5;
  localparam logic [3:0] c_op_sltu = 4'd6;
  localparam logic [3:0] c_op_sll  = 4'd7;
  localparam logic [3:0] c_op_srl  = 4'd8;
  localparam logic [3:0] c_op_sra  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Architectural state
  state_e            state_q;
  logic              started_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   result_q;
  logic [TAG_W-1:0]  tag_q;
  logic              illegal_q;

  // Iterative shifter state
  logic [XLEN-1:0]   sh_val_q;
  logic [c_remw-1:0] sh_rem_q;
  logic [3:0]        sh_op_q;
  logic              sh_w_q;
  logic [TAG_W-1:0]  sh_tag_q;

  // Shifter next-state values
  logic [XLEN-1:0]   sh_val_d;
  logic [c_remw-1:0] sh_rem_d;

  // Combinational datapath
  logic [XLEN-1:0]   w_a_in;
  logic [XLEN-1:0]   w_b_in;
  logic [XLEN-1:0]   w_a_zext;
  logic [XLEN-1:0]   w_a_sext;
  logic [XLEN-1:0]   w_alu_raw;
  logic [XLEN-1:0]   w_alu_sext;
  logic [XLEN-1:0]   w_alu_res;
  logic [XLEN-1:0]   w_sh_init;
  logic [XLEN-1:0]   w_sh_sext;
  logic [XLEN-1:0]   w_sh_res;
  logic [c_remw-1:0] w_shamt;
  logic [c_remw-1:0] w_amt;
  logic              w_is_shift;
  logic              w_illegal_op;
  logic              w_word;
  logic              w_sh_done;
  logic              w_accept;

  // ---------------------------------------------------------------------------
  // Operand selection (bypass only looks at the live inputs of the accept cycle)
  // ---------------------------------------------------------------------------
`ifdef ALU_BYPASS_EN
  assign w_a_in = ((a_idx == byp_idx) && (byp_idx != 5'd0)) ? byp_val : a;
  assign w_b_in = ((b_idx == byp_idx) && (byp_idx != 5'd0)) ? byp_val : b;
`else
  logic w_unused_byp;
  assign w_a_in       = a;
  assign w_b_in       = b;
  assign w_unused_byp = ^{a_idx, b_idx, byp_idx, byp_val};
`endif

  // ---------------------------------------------------------------------------
  // Op decode
  // ---------------------------------------------------------------------------
  assign w_is_shift   = (op == c_op_sll) || (op == c_op_srl) || (op == c_op_sra);
  assign w_illegal_op = (op > c_op_sra);

  // Word ops exist only on RV64 and only for add/sub/shift; logic and compare ignore op_w.
  assign w_word = (XLEN == 64) && op_w &&
                  ((op == c_op_add) || (op == c_op_sub) || w_is_shift);

  // Word shifts use the 5-bit shift amount, full-width shifts use log2(XLEN) bits.
  assign w_shamt = w_word ? c_remw'(w_b_in[4:0]) : c_remw'(w_b_in[c_shw-1:0]);

  // ---------------------------------------------------------------------------
  // 32-bit sign/zero extension helpers; identity on RV32
  // ---------------------------------------------------------------------------
  generate
    if (XLEN == 64) begin : g_xlen64
      assign w_a_zext   = {{(XLEN-32){1'b0}},         w_a_in[31:0]};
      assign w_a_sext   = {{(XLEN-32){w_a_in[31]}},    w_a_in[31:0]};
      assign w_alu_sext = {{(XLEN-32){w_alu_raw[31]}}, w_alu_raw[31:0]};
      assign w_sh_sext  = {{(XLEN-32){sh_val_d[31]}},  sh_val_d[31:0]};
    end else begin : g_xlen32
      assign w_a_zext   = w_a_in;
      assign w_a_sext   = w_a_in;
      assign w_alu_sext = w_alu_raw;
      assign w_sh_sext  = sh_val_d;
    end
  endgenerate

  // Shifter preload: SRLW/SRAW first extend a[31:0] so the wide shift fills correctly.
  always_comb begin
    w_sh_init = w_a_in;
    if (w_word && (op == c_op_srl)) begin
      w_sh_init = w_a_zext;
    end else if (w_word && (op == c_op_sra)) begin
      w_sh_init = w_a_sext;
    end
  end

  // Single-cycle result; shifts land here only when the shift amount is zero.
  always_comb begin
    w_alu_raw = '0;
    case (op)
      c_op_add:  w_alu_raw = w_a_in + w_b_in;
      c_op_sub:  w_alu_raw = w_a_in - w_b_in;
      c_op_and:  w_alu_raw = w_a_in & w_b_in;
      c_op_or:   w_alu_raw = w_a_in | w_b_in;
      c_op_xor:  w_alu_raw = w_a_in ^ w_b_in;
      c_op_slt:  w_alu_raw = {{(XLEN-1){1'b0}}, ($signed(w_a_in) < $signed(w_b_in))};
      c_op_sltu: w_alu_raw = {{(XLEN-1){1'b0}}, (w_a_in < w_b_in)};
      c_op_sll,
      c_op_srl,
      c_op_sra:  w_alu_raw = w_sh_init;
      default:   w_alu_raw = '0;
    endcase
  end

  assign w_alu_res = w_word ? w_alu_sext : w_alu_raw;

  // ---------------------------------------------------------------------------
  // Iterative shifter: each cycle moves min(SHIFT_STEP, remaining) bits
  // ---------------------------------------------------------------------------
  assign w_amt    = (sh_rem_q > c_step) ? c_step : sh_rem_q;
  assign sh_rem_d = sh_rem_q - w_amt;
  assign w_sh_done = (sh_rem_d == '0);

  // One shift step in the direction/fill chosen at accept time.
  always_comb begin
    sh_val_d = sh_val_q;
    case (sh_op_q)
      c_op_sll: sh_val_d = sh_val_q << w_amt;
      c_op_srl: sh_val_d = sh_val_q >> w_amt;
      c_op_sra: sh_val_d = $signed(sh_val_q) >>> w_amt;
      default:  sh_val_d = sh_val_q;
    endcase
  end

  assign w_sh_res = sh_w_q ? w_sh_sext : sh_val_d;

  // ---------------------------------------------------------------------------
  // Handshake: started_q holds in_ready low for the first cycle after reset.
  // ---------------------------------------------------------------------------
  assign in_ready = started_q && !cancel &&
                    ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
  assign w_accept = in_valid && in_ready;

  // Control FSM with registered result/tag/illegal; cancel overrides everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      started_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
      illegal_q   <= 1'b0;
      sh_val_q    <= '0;
      sh_rem_q    <= '0;
      sh_op_q     <= c_op_sll;
      sh_w_q      <= 1'b0;
      sh_tag_q    <= '0;
    end else begin
      started_q <= 1'b1;
      if (cancel) begin
        // Drop any partial shift or held result; result/tag keep their value.
        state_q     <= ST_IDLE;
        out_valid_q <= 1'b0;
      end else if (w_accept) begin
        // Accept happens from IDLE or from HOLD while the old result is consumed.
        if (w_illegal_op) begin
          state_q     <= ST_HOLD;
          out_valid_q <= 1'b1;
          result_q    <= '0;
          tag_q       <= tag_in;
          illegal_q   <= 1'b1;
        end else if (w_is_shift && (w_shamt != '0)) begin
          state_q     <= ST_SHIFT;
          out_valid_q <= 1'b0;
          sh_val_q    <= w_sh_init;
          sh_rem_q    <= w_shamt;
          sh_op_q     <= op;
          sh_w_q      <= w_word;
          sh_tag_q    <= tag_in;
        end else begin
          state_q     <= ST_HOLD;
          out_valid_q <= 1'b1;
          result_q    <= w_alu_res;
          tag_q       <= tag_in;
          illegal_q   <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_SHIFT: begin
            sh_val_q <= sh_val_d;
            sh_rem_q <= sh_rem_d;
            if (w_sh_done) begin
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
              result_q    <= w_sh_res;
              tag_q       <= sh_tag_q;
              illegal_q   <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (out_ready) begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign tag_out   = tag_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_alu_mc
// Description : Scoreboard bench for rv_alu_mc. Three instances: RV32 with
//               SHIFT_STEP=1, RV32 with SHIFT_STEP=4 and RV64 with
//               SHIFT_STEP=1. Stimulus pushes expected results into per-DUT
//               queues; a monitor pops and compares on each output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_alu_mc;

`ifdef ALU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
  localparam logic [3:0] SLT = 4'd5, SLTU = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  in_valid_v;
  logic [2:0]  ir_v;
  logic [2:0]  ov_v;
  logic [2:0]  ordy_v;
  logic [2:0]  cancel_v;
  logic [2:0]  ill_v;
  logic [3:0]  op_r;
  logic        opw_r;
  logic [63:0] a_r, b_r, byp_val_r;
  logic [4:0]  a_idx_r, b_idx_r, byp_idx_r, tag_r;
  logic [31:0] res0, res1;
  logic [63:0] res2;
  logic [4:0]  tag0, tag1, tag2;

  always #5 clk = ~clk;

  rv_alu_mc #(.XLEN(32), .SHIFT_STEP(1), .TAG_W(5)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_v[0]), .in_ready(ir_v[0]),
    .op(op_r), .op_w(opw_r), .a(a_r[31:0]), .b(b_r[31:0]), .a_idx(a_idx_r), .b_idx(b_idx_r),
    .tag_in(tag_r), .byp_idx(byp_idx_r), .byp_val(byp_val_r[31:0]), .cancel(cancel_v[0]),
    .out_valid(ov_v[0]), .out_ready(ordy_v[0]), .result(res0), .tag_out(tag0), .illegal(ill_v[0])
  );

  rv_alu_mc #(.XLEN(32), .SHIFT_STEP(4), .TAG_W(5)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_v[1]), .in_ready(ir_v[1]),
    .op(op_r), .op_w(opw_r), .a(a_r[31:0]), .b(b_r[31:0]), .a_idx(a_idx_r), .b_idx(b_idx_r),
    .tag_in(tag_r), .byp_idx(byp_idx_r), .byp_val(byp_val_r[31:0]), .cancel(cancel_v[1]),
    .out_valid(ov_v[1]), .out_ready(ordy_v[1]), .result(res1), .tag_out(tag1), .illegal(ill_v[1])
  );

  rv_alu_mc #(.XLEN(64), .SHIFT_STEP(1), .TAG_W(5)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_v[2]), .in_ready(ir_v[2]),
    .op(op_r), .op_w(opw_r), .a(a_r), .b(b_r), .a_idx(a_idx_r), .b_idx(b_idx_r),
    .tag_in(tag_r), .byp_idx(byp_idx_r), .byp_val(byp_val_r), .cancel(cancel_v[2]),
    .out_valid(ov_v[2]), .out_ready(ordy_v[2]), .result(res2), .tag_out(tag2), .illegal(ill_v[2])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one op to DUT sel; optionally push its expected response.
  task automatic issue(input int sel, input logic [3:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                       input logic [63:0] exp_res, input logic exp_ill, input bit push,
                       output int waits);
    exp_t e;
    bit   ok;
    op_r = op; opw_r = w; a_r = a; b_r = b; tag_r = tag;
    in_valid_v[sel] = 1'b1;
    waits = 0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ir_v[sel]) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout dut%0d op=%0d actual=no_accept required=accept", sel, op);
    end else if (push) begin
      e.res = exp_res; e.tag = tag; e.ill = exp_ill;
      case (sel)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    @(posedge clk);
    #1;
    in_valid_v[sel] = 1'b0;
  endtask

  // Count cycles from accept until out_valid; note any in_ready pulse meanwhile.
  task automatic wait_valid(input int sel, output int n, output bit ir_seen);
    n = 0;
    ir_seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      n++;
      if (ov_v[sel]) break;
      if (ir_v[sel]) ir_seen = 1'b1;
    end
  endtask

  // Scoreboard monitor: compare on every output handshake.
  always @(negedge clk) begin : mon
    exp_t        e;
    bit          have;
    logic [63:0] r;
    logic [4:0]  t;
    logic        il;
    for (int i = 0; i < 3; i++) begin
      if (reset_n && ov_v[i] && ordy_v[i] && !cancel_v[i]) begin
        have = 1'b0;
        case (i)
          0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        r  = (i == 0) ? {32'h0, res0} : (i == 1) ? {32'h0, res1} : res2;
        t  = (i == 0) ? tag0 : (i == 1) ? tag1 : tag2;
        il = ill_v[i];
        if (!have) begin
          checks++;
          errors++;
          $display("FAIL mon%0d_unexpected actual=%h tag=%0d required=no_output", i, r, t);
        end else begin
          chk($sformatf("mon%0d_result", i), r, e.res);
          chk($sformatf("mon%0d_tag", i), {59'h0, t}, {59'h0, e.tag});
          chk($sformatf("mon%0d_illegal", i), {63'h0, il}, {63'h0, e.ill});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int  w, n;
    bit  irs;
    reset_n = 1'b0;
    in_valid_v = '0; ordy_v = '1; cancel_v = '0;
    op_r = ADD; opw_r = 1'b0; a_r = '0; b_r = '0; tag_r = '0;
    a_idx_r = '0; b_idx_r = '0; byp_idx_r = '0; byp_val_r = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'h0, ir_v[0]}, 64'h0);
    chk("rst_out_valid", {63'h0, ov_v[0]}, 64'h0);
    chk("rst_result", {32'h0, res0}, 64'h0);
    chk("rst_tag", {59'h0, tag0}, 64'h0);
    chk("rst_illegal", {63'h0, ill_v[0]}, 64'h0);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready_low", {63'h0, ir_v[0]}, 64'h0);
    @(negedge clk);
    chk("release_in_ready_high", {63'h0, ir_v[0]}, 64'h1);
    @(posedge clk);
    #1;

    // ADD wrap with tag, one-cycle latency
    issue(0, ADD, 1'b0, 64'hFFFF_FFFF, 64'h1, 5'd7, 64'h0, 1'b0, 1'b1, w);
    @(negedge clk);
    chk("add_latency_valid", {63'h0, ov_v[0]}, 64'h1);
    @(posedge clk);
    #1;

    // Back-to-back logic ops at full throughput
    issue(0, AND_, 1'b0, 64'hF0F0_F0F0, 64'hFF00_FF00, 5'd1, 64'hF000_F000, 1'b0, 1'b1, w);
    chk("b2b_and_waits", w, 0);
    issue(0, OR_, 1'b0, 64'hF0F0_F0F0, 64'hFF00_FF00, 5'd2, 64'hFFF0_FFF0, 1'b0, 1'b1, w);
    chk("b2b_or_waits", w, 0);
    issue(0, XOR_, 1'b0, 64'hF0F0_F0F0, 64'hFF00_FF00, 5'd3, 64'h0FF0_0FF0, 1'b0, 1'b1, w);
    chk("b2b_xor_waits", w, 0);

    // Signed vs unsigned compare
    issue(0, SLT, 1'b0, 64'hFFFF_FFFF, 64'h1, 5'd4, 64'h1, 1'b0, 1'b1, w);
    issue(0, SLTU, 1'b0, 64'hFFFF_FFFF, 64'h1, 5'd5, 64'h0, 1'b0, 1'b1, w);

    // Illegal opcode, then a legal op clears the flag
    issue(0, 4'd12, 1'b0, 64'h5, 64'h6, 5'd2, 64'h0, 1'b1, 1'b1, w);
    issue(0, ADD, 1'b0, 64'h1, 64'h1, 5'd1, 64'h2, 1'b0, 1'b1, w);

    // Shifts on the one-bit-per-cycle shifter
    issue(0, SRA, 1'b0, 64'h8000_0010, 64'h4, 5'd10, 64'hF800_0001, 1'b0, 1'b1, w);
    wait_valid(0, n, irs);
    chk("sra_step1_latency", n, 5);
    @(posedge clk);
    #1;
    issue(0, SRL, 1'b0, 64'h8000_0010, 64'h4, 5'd11, 64'h0800_0001, 1'b0, 1'b1, w);
    issue(0, SLL, 1'b0, 64'h1, 64'h0, 5'd12, 64'h1, 1'b0, 1'b1, w);
    wait_valid(0, n, irs);
    chk("sll_zero_latency", n, 1);
    @(posedge clk);
    #1;
    issue(0, SLL, 1'b0, 64'h3, 64'd34, 5'd13, 64'hC, 1'b0, 1'b1, w);

    // Bypass (or its absence in the default build)
    a_idx_r = 5'd3; byp_idx_r = 5'd3; byp_val_r = 64'd100;
    issue(0, ADD, 1'b0, 64'h0, 64'h1, 5'd14, BYP ? 64'd101 : 64'd1, 1'b0, 1'b1, w);
    byp_idx_r = 5'd0;
    issue(0, ADD, 1'b0, 64'h0, 64'h1, 5'd15, 64'd1, 1'b0, 1'b1, w);
    a_idx_r = 5'd0; b_idx_r = 5'd5; byp_idx_r = 5'd5; byp_val_r = 64'd7;
    issue(0, ADD, 1'b0, 64'h1, 64'h0, 5'd16, BYP ? 64'd8 : 64'd1, 1'b0, 1'b1, w);
    b_idx_r = 5'd0; byp_idx_r = 5'd0; byp_val_r = 64'd0;

    // Backpressure: SUB result held for 3 cycles with the next op waiting
    issue(0, SUB, 1'b0, 64'h5, 64'h7, 5'd3, 64'hFFFF_FFFE, 1'b0, 1'b1, w);
    ordy_v[0] = 1'b0;
    op_r = ADD; opw_r = 1'b0; a_r = 64'd10; b_r = 64'd20; tag_r = 5'd4;
    in_valid_v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", {63'h0, ov_v[0]}, 64'h1);
      chk("hold_result", {32'h0, res0}, 64'hFFFF_FFFE);
      chk("hold_tag", {59'h0, tag0}, 64'h3);
      chk("hold_in_ready", {63'h0, ir_v[0]}, 64'h0);
    end
    @(posedge clk);
    #1;
    ordy_v[0] = 1'b1;
    issue(0, ADD, 1'b0, 64'd10, 64'd20, 5'd4, 64'd30, 1'b0, 1'b1, w);
    chk("consume_accept_waits", w, 0);

    // Cancel mid-shift; an op offered in the cancel cycle must not be taken
    issue(0, SLL, 1'b0, 64'h1, 64'd20, 5'd6, 64'h0, 1'b0, 1'b0, w);
    repeat (4) @(posedge clk);
    #1;
    cancel_v[0] = 1'b1;
    op_r = ADD; a_r = 64'd2; b_r = 64'd3; tag_r = 5'd8;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    chk("cancel_in_ready", {63'h0, ir_v[0]}, 64'h0);
    @(posedge clk);
    #1;
    cancel_v[0] = 1'b0;
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    chk("post_cancel_in_ready", {63'h0, ir_v[0]}, 64'h1);
    chk("post_cancel_valid", {63'h0, ov_v[0]}, 64'h0);
    chk("post_cancel_result_kept", {32'h0, res0}, 64'd30);
    @(posedge clk);
    #1;
    issue(0, ADD, 1'b0, 64'd2, 64'd3, 5'd8, 64'd5, 1'b0, 1'b1, w);

    // SHIFT_STEP=4 instance
    issue(1, SRA, 1'b0, 64'h8000_0000, 64'd31, 5'd9, 64'hFFFF_FFFF, 1'b0, 1'b1, w);
    wait_valid(1, n, irs);
    chk("sra_step4_latency", n, 9);
    chk("sra_step4_in_ready_low", {63'h0, irs}, 64'h0);
    @(posedge clk);
    #1;
    issue(1, SLL, 1'b0, 64'h1, 64'd6, 5'd17, 64'h40, 1'b0, 1'b1, w);
    wait_valid(1, n, irs);
    chk("sll_step4_latency", n, 3);
    @(posedge clk);
    #1;
    issue(1, SRL, 1'b0, 64'h80, 64'd3, 5'd18, 64'h10, 1'b0, 1'b1, w);
    wait_valid(1, n, irs);
    chk("srl_step4_partial_latency", n, 2);
    @(posedge clk);
    #1;

    // RV64 instance: word ops and full-width ops
    issue(2, SLL, 1'b1, 64'h1, 64'd31, 5'd20, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, w);
    issue(2, ADD, 1'b1, 64'h7FFF_FFFF, 64'h1, 5'd21, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, w);
    issue(2, ADD, 1'b0, 64'h7FFF_FFFF, 64'h1, 5'd22, 64'h0000_0000_8000_0000, 1'b0, 1'b1, w);
    issue(2, SUB, 1'b1, 64'h1_0000_0000, 64'h0, 5'd23, 64'h0, 1'b0, 1'b1, w);
    issue(2, SUB, 1'b0, 64'h1_0000_0000, 64'h0, 5'd24, 64'h1_0000_0000, 1'b0, 1'b1, w);
    issue(2, SLT, 1'b1, 64'h1_0000_0000, 64'h1, 5'd25, 64'h0, 1'b0, 1'b1, w);
    issue(2, SRA, 1'b1, 64'h8000_0000, 64'd4, 5'd26, 64'hFFFF_FFFF_F800_0000, 1'b0, 1'b1, w);
    issue(2, SRL, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 5'd27, 64'h0000_0000_0800_0000, 1'b0, 1'b1, w);
    issue(2, SRL, 1'b0, 64'h8000_0000_0000_0000, 64'd36, 5'd28, 64'h0000_0000_0800_0000, 1'b0, 1'b1, w);
    wait_valid(2, n, irs);
    chk("srl64_latency", n, 37);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a shift
    issue(0, SRL, 1'b0, 64'hFFFF_FFFF, 64'd20, 5'd29, 64'h0, 1'b0, 1'b0, w);
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midshift_rst_valid", {63'h0, ov_v[0]}, 64'h0);
    chk("midshift_rst_result", {32'h0, res0}, 64'h0);
    chk("midshift_rst_tag", {59'h0, tag0}, 64'h0);
    chk("midshift_rst_in_ready", {63'h0, ir_v[0]}, 64'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rerelease_in_ready_low", {63'h0, ir_v[0]}, 64'h0);
    @(negedge clk);
    chk("rerelease_in_ready_high", {63'h0, ir_v[0]}, 64'h1);
    @(posedge clk);
    #1;
    issue(0, ADD, 1'b0, 64'h2, 64'h2, 5'd1, 64'h4, 1'b0, 1'b1, w);
    repeat (30) @(negedge clk);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
